// File: rtl/fir_pkg.sv
// Shared types and helpers for the FIR sequencing controller.
package fir_pkg;

  localparam int unsigned TapsDefault = 32;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StDump
  } fir_state_e;

endpackage

// File: rtl/fir_seq_ctrl_if.sv
// Sample/result handshake and MAC datapath control bundle of the FIR sequencer.
interface fir_seq_ctrl_if
  import fir_pkg::*;
#(
  parameter int unsigned AW = clog2(TapsDefault)
);

  logic          in_valid;
  logic          in_ready;
  logic          data_in_en;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] data_counter;
  logic [AW-1:0] co_choose;
  logic          acc_clr;
  logic          add_en;
  logic          out_en;
  logic          out_valid;
  logic          out_ready;
  logic          busy;

  modport master (
    input  in_valid, out_ready,
    output in_ready, data_in_en, wr_ptr, data_counter, co_choose,
    output acc_clr, add_en, out_en, out_valid, busy
  );

  modport slave (
    output in_valid, out_ready,
    input  in_ready, data_in_en, wr_ptr, data_counter, co_choose,
    input  acc_clr, add_en, out_en, out_valid, busy
  );

endinterface

// File: rtl/mod_counter.sv
// Modulo-N up counter with enable and synchronous clear (clear has priority).
module mod_counter
  import fir_pkg::*;
#(
  parameter int unsigned Modulus = TapsDefault,
  parameter int unsigned Width   = clog2(Modulus)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o
);

  localparam logic [Width-1:0] Last = Width'(Modulus - 1);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == Last) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fir_seq_ctrl.sv
// FIR sequencer: accepts a sample, walks TAPS MAC cycles over the delay line, then
// hands the accumulated result to the output register with a valid/ready handshake.
module fir_seq_ctrl
  import fir_pkg::*;
#(
  parameter int unsigned TAPS = TapsDefault,
  parameter int unsigned AW   = clog2(TAPS)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en_i,
  input  logic           flush_i,
  fir_seq_ctrl_if.master ctrl_io
);

  localparam int unsigned     AW1     = AW + 1;
  localparam logic [AW-1:0]   LastTap = AW'(TAPS - 1);
  localparam logic [AW:0]     TapsW   = AW1'(TAPS);

  fir_state_e    state_q, state_d;
  logic [AW-1:0] wr_ptr, tap_cnt;
  logic [AW-1:0] newest_q, newest_d;
  logic          out_valid_q, out_valid_d;
  logic          in_ready, data_in_en, out_en, add_en, acc_clr;
  logic [AW-1:0] co_choose, data_counter;
  logic [AW:0]   tap_dist;

  mod_counter #(
    .Modulus(TAPS),
    .Width  (AW)
  ) u_wr_ptr (
    .clk  (clk),
    .rst_n(rst_n),
    .clr_i(flush_i),
    .en_i (data_in_en),
    .cnt_o(wr_ptr)
  );

  mod_counter #(
    .Modulus(TAPS),
    .Width  (AW)
  ) u_tap_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr_i(flush_i | (state_q != StMac)),
    .en_i (state_q == StMac),
    .cnt_o(tap_cnt)
  );

  // Read address walks backwards from the newest sample, wrapping at TAPS.
  always_comb begin
    tap_dist = {1'b0, newest_q} + TapsW - {1'b0, tap_cnt};
    if (tap_dist >= TapsW) tap_dist = tap_dist - TapsW;
  end

  assign data_in_en = ctrl_io.in_valid & in_ready;

  always_comb begin
    state_d      = state_q;
    in_ready     = 1'b0;
    out_en       = 1'b0;
    add_en       = 1'b0;
    acc_clr      = 1'b0;
    co_choose    = '0;
    data_counter = wr_ptr;
    unique case (state_q)
      StIdle: begin
        // Gating with rst_n keeps the handshake quiet while reset is held.
        in_ready = rst_n & en_i & ~flush_i;
        if (ctrl_io.in_valid && in_ready) state_d = StMac;
      end
      StMac: begin
        add_en       = 1'b1;
        acc_clr      = (tap_cnt == '0);
        co_choose    = tap_cnt;
        data_counter = tap_dist[AW-1:0];
        if (tap_cnt == LastTap) state_d = StDump;
      end
      StDump: begin
        out_en = ~flush_i & (~out_valid_q | ctrl_io.out_ready);
        if (out_en) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (flush_i) state_d = StIdle;
  end

  // A new load wins over a same-cycle downstream accept.
  always_comb begin
    newest_d    = newest_q;
    out_valid_d = out_valid_q;
    if (flush_i) begin
      newest_d    = '0;
      out_valid_d = 1'b0;
    end else begin
      if (data_in_en) newest_d = wr_ptr;
      if (out_en) begin
        out_valid_d = 1'b1;
      end else if (out_valid_q && ctrl_io.out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      newest_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      newest_q    <= newest_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign ctrl_io.in_ready     = in_ready;
  assign ctrl_io.data_in_en   = data_in_en;
  assign ctrl_io.wr_ptr       = wr_ptr;
  assign ctrl_io.data_counter = data_counter;
  assign ctrl_io.co_choose    = co_choose;
  assign ctrl_io.acc_clr      = acc_clr;
  assign ctrl_io.add_en       = add_en;
  assign ctrl_io.out_en       = out_en;
  assign ctrl_io.out_valid    = out_valid_q;
  assign ctrl_io.busy         = (state_q != StIdle);

endmodule

// File: doc/fir_seq_ctrl.md
FIR_SEQ_CTRL -- requirements
Module: fir_seq_ctrl

Interface
REQ-001 Parameter TAPS, default 32, legal 2..256: number of filter taps, one MAC cycle each.
REQ-002 Parameter AW, default $clog2(TAPS): width of all tap/address buses.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 en  in  1  enable; low blocks new sample acceptance only.
REQ-006 flush  in  1  synchronous abort; clears pointer and output state.
REQ-007 in_valid  in  1  upstream sample valid.
REQ-008 in_ready  out  1  high in IDLE when en=1 and flush=0 (combinational from state).
REQ-009 data_in_en  out  1  delay-line write strobe; equals in_valid & in_ready.
REQ-010 wr_ptr  out  AW  delay-line write address.
REQ-011 data_counter  out  AW  delay-line read address for current tap.
REQ-012 co_choose  out  AW  coefficient index for current tap.
REQ-013 acc_clr  out  1  accumulator clear (load-not-add) on first tap.
REQ-014 add_en  out  1  accumulator enable, high every MAC cycle.
REQ-015 out_en  out  1  output-register load strobe, one cycle.
REQ-016 out_valid  out  1  output-register contents valid.
REQ-017 out_ready  in  1  downstream accepts output.
REQ-018 busy  out  1  high whenever state is not IDLE.

Function
REQ-019 FSM states IDLE, MAC, DUMP; IDLE->MAC on data_in_en; MAC->DUMP after TAPS cycles; DUMP->IDLE when out_en fires.
REQ-020 On acceptance, the accepted sample is written at wr_ptr; wr_ptr captured as newest index, then increments modulo TAPS (TAPS-1 -> 0, non-power-of-2 included).
REQ-021 MAC cycle k (k=0..TAPS-1): co_choose=k, data_counter=(newest-k) mod TAPS, add_en=1, acc_clr=1 only at k=0.
REQ-022 DUMP: out_en=1 if out_valid=0 or out_ready=1; otherwise stay in DUMP (stall), out_en=0.
REQ-023 out_valid sets the cycle after out_en; clears after out_valid & out_ready with no out_en in the same cycle; out_en wins when both occur.
REQ-024 Latency: sample accepted in cycle t -> out_en at t+TAPS+1, out_valid at t+TAPS+2 with no backpressure; throughput one sample per TAPS+2 cycles.
REQ-025 en low during MAC/DUMP: current sample completes normally; no new acceptance.
REQ-026 flush: next state IDLE, wr_ptr=0, out_valid=0, no out_en; flush with in_valid in same cycle -> sample not accepted.
REQ-027 Outside MAC: add_en=0, acc_clr=0, co_choose=0, data_counter=wr_ptr.

Reset
REQ-028 rst_n low: state IDLE, wr_ptr=0, newest=0, tap counter=0, out_valid=0, all strobes 0, data_counter=0, co_choose=0, effective immediately including mid-MAC.
REQ-029 First acceptance possible in the first clock after rst_n deasserts.

Structure
REQ-030 Shared package fir_pkg holds TAPS default, clog2 helper and the state enum.
REQ-031 One sub-module mod_counter (AW-wide, modulo TAPS, enable, sync clear) instantiated for wr_ptr and the tap counter.

Verification
REQ-032 TAPS=32, one sample at t=10, out_ready=1 -> add_en high t=11..42, acc_clr only t=11, out_en t=43, out_valid t=44..44.
REQ-033 TAPS=5, 7 back-to-back samples -> wr_ptr sequence 0,1,2,3,4,0,1; 7th MAC data_counter = 1,0,4,3,2.
REQ-034 TAPS=32, out_ready=0 for 40 cycles after first result, second sample sent -> stall in DUMP, busy=1, in_ready=0, out_en fires the cycle out_ready rises.
REQ-035 flush asserted at MAC cycle 7 with in_valid=1 -> IDLE next cycle, wr_ptr=0, no out_en, sample not accepted.
REQ-036 rst_n pulled low at MAC cycle 15 -> all outputs 0 asynchronously, busy=0; after release a new sample yields out_valid exactly TAPS+2 cycles later.
REQ-037 en=0 while in_valid=1 in IDLE -> in_ready=0, data_in_en=0, no state change for 20 cycles.
